sc_spi_sss_multi: RTL and testbench



---
 rtl/sc_spi_pkg.sv | 19 +
 rtl/sc_spi_sss_ch.sv | 72 +++++++
 rtl/sc_spi_sss_multi.sv | 56 +++++
 tb/tb_sc_spi_sss_multi.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sc_spi_pkg.sv
// Shared definitions for the SPI-engine input synchronizer.
// Channel modes and per-channel mode extraction.
package sc_spi_pkg;

  localparam logic [1:0] SC_SSS_LEVEL  = 2'b00;
  localparam logic [1:0] SC_SSS_TOGGLE = 2'b01;
  localparam logic [1:0] SC_SSS_RISE   = 2'b10;
  localparam logic [1:0] SC_SSS_FALL   = 2'b11;

  localparam int SC_SSS_MAX_CH = 32;

  function automatic logic [1:0] sss_mode(
    input logic [2*SC_SSS_MAX_CH-1:0] mode,
    input int                         ch
  );
    return mode[2*ch +: 2];
  endfunction

endpackage

// File: rtl/sc_spi_sss_ch.sv
// One synchronizer channel: sync chain, glitch filter,
// delayed level and registered per-mode event.
module sc_spi_sss_ch
  import sc_spi_pkg::*;
#(
  parameter int         STAGES  = 2,
  parameter int         FILT_W  = 4,
  parameter logic [1:0] MODE_CH = SC_SSS_TOGGLE,
  parameter logic       INIT_CH = 1'b0
) (
  input  logic              SYSCLK,
  input  logic              SYSRST,
  input  logic              din,
  input  logic [FILT_W-1:0] filt_cnt,
  output logic              level,
  output logic              evt
);

  logic [STAGES-1:0] sync_q;
  logic [FILT_W-1:0] cnt_q;
  logic              s;
  logic              f_q;
  logic              f_d;
  logic              evt_nxt;

  assign s     = sync_q[STAGES-1];
  assign level = f_q;

  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) begin
      sync_q <= {STAGES{INIT_CH}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
    end
  end

  // >= keeps a lowered threshold from stranding cnt above it
  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) begin
      f_q   <= INIT_CH;
      cnt_q <= '0;
    end else if (s == f_q) begin
      cnt_q <= '0;
    end else if (cnt_q >= filt_cnt) begin
      f_q   <= s;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    evt_nxt = f_q;
    unique case (MODE_CH)
      SC_SSS_LEVEL:  evt_nxt = f_q;
      SC_SSS_TOGGLE: evt_nxt = f_q ^ f_d;
      SC_SSS_RISE:   evt_nxt = f_q & ~f_d;
      SC_SSS_FALL:   evt_nxt = ~f_q & f_d;
    endcase
  end

  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) begin
      f_d <= INIT_CH;
      evt <= 1'b0;
    end else begin
      f_d <= f_q;
      evt <= evt_nxt;
    end
  end

endmodule

// File: rtl/sc_spi_sss_multi.sv
// Multi-channel input synchronizer with sticky event
// flags (write-one-to-clear) and OR-reduced interrupt.
module sc_spi_sss_multi
  import sc_spi_pkg::*;
#(
  parameter int              CH     = 4,
  parameter int              STAGES = 2,
  parameter int              FILT_W = 4,
  parameter logic [2*CH-1:0] MODE   = {CH{2'b01}},
  parameter logic [CH-1:0]   INIT   = {CH{1'b0}}
) (
  input  logic              SYSCLK,
  input  logic              SYSRST,
  input  logic [CH-1:0]     ASYNC_IN,
  input  logic [FILT_W-1:0] FILT_CNT,
  input  logic [CH-1:0]     CLR,
  output logic [CH-1:0]     SYNC_OUT,
  output logic [CH-1:0]     EVENT,
  output logic [CH-1:0]     STICKY,
  output logic              IRQ
);

  logic [CH-1:0] pulse_en;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    localparam logic [1:0] M = sss_mode(64'(MODE), i);

    assign pulse_en[i] = (M != SC_SSS_LEVEL);

    sc_spi_sss_ch #(
      .STAGES  (STAGES),
      .FILT_W  (FILT_W),
      .MODE_CH (M),
      .INIT_CH (INIT[i])
    ) u_ch (
      .SYSCLK   (SYSCLK),
      .SYSRST   (SYSRST),
      .din      (ASYNC_IN[i]),
      .filt_cnt (FILT_CNT),
      .level    (SYNC_OUT[i]),
      .evt      (EVENT[i])
    );
  end

  // set has priority over a simultaneous clear
  always_ff @(posedge SYSCLK or posedge SYSRST) begin
    if (SYSRST) begin
      STICKY <= '0;
    end else begin
      STICKY <= (STICKY & ~CLR) | (EVENT & pulse_en);
    end
  end

  assign IRQ = |STICKY;

endmodule

// File: tb/tb_sc_spi_sss_multi.sv
// Directed bench for sc_spi_sss_multi: ch0 toggle, ch1 rise,
// ch2 fall, ch3 level, INIT=0101.
module tb_sc_spi_sss_multi;

  localparam int CH = 4;
  localparam int FW = 4;

  logic          SYSCLK = 1'b0;
  logic          SYSRST;
  logic [CH-1:0] ASYNC_IN;
  logic [FW-1:0] FILT_CNT;
  logic [CH-1:0] CLR;
  logic [CH-1:0] SYNC_OUT;
  logic [CH-1:0] EVENT;
  logic [CH-1:0] STICKY;
  logic          IRQ;

  int vectors = 0;
  int fails   = 0;

  always #5 SYSCLK = ~SYSCLK;

  sc_spi_sss_multi #(
    .CH     (CH),
    .STAGES (2),
    .FILT_W (FW),
    .MODE   (8'b00_11_10_01),
    .INIT   (4'b0101)
  ) dut (
    .SYSCLK   (SYSCLK),
    .SYSRST   (SYSRST),
    .ASYNC_IN (ASYNC_IN),
    .FILT_CNT (FILT_CNT),
    .CLR      (CLR),
    .SYNC_OUT (SYNC_OUT),
    .EVENT    (EVENT),
    .STICKY   (STICKY),
    .IRQ      (IRQ)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge SYSCLK);
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int n_ev0, n_hi0, n_ev2, n_hi2;
  logic [CH-1:0] prev_ev;

  initial begin
    SYSRST   = 1'b1;
    ASYNC_IN = 4'b0101;
    FILT_CNT = '0;
    CLR      = '0;
    #1;
    check("rst_sync", 32'(SYNC_OUT), 32'h5);
    check("rst_event", 32'(EVENT), 32'h0);
    check("rst_sticky", 32'(STICKY), 32'h0);
    check("rst_irq", 32'(IRQ), 32'h0);
    tick(2);
    SYSRST = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      check("post_rst_event", 32'(EVENT), 32'h0);
    end
    check("post_rst_sync", 32'(SYNC_OUT), 32'h5);

    // rise on ch1, FILT_CNT=0
    ASYNC_IN[1] = 1'b1;
    tick(2);
    check("rise_e2_sync", 32'(SYNC_OUT[1]), 32'h0);
    tick(1);
    check("rise_e3_sync", 32'(SYNC_OUT[1]), 32'h1);
    check("rise_e3_evt", 32'(EVENT[1]), 32'h0);
    tick(1);
    check("rise_e4_evt", 32'(EVENT[1]), 32'h1);
    check("rise_e4_sticky", 32'(STICKY[1]), 32'h0);
    tick(1);
    check("rise_e5_evt", 32'(EVENT[1]), 32'h0);
    check("rise_e5_sticky", 32'(STICKY[1]), 32'h1);
    check("rise_e5_irq", 32'(IRQ), 32'h1);
    CLR = 4'b0010;
    tick(1);
    CLR = '0;
    check("clr1_sticky", 32'(STICKY), 32'h0);
    check("clr1_irq", 32'(IRQ), 32'h0);

    // falling edge on a rise channel sets nothing
    ASYNC_IN[1] = 1'b0;
    tick(6);
    check("rise_fall_sync", 32'(SYNC_OUT[1]), 32'h0);
    check("rise_fall_sticky", 32'(STICKY), 32'h0);

    // filter: 3-wide glitch rejected
    FILT_CNT = 4'd3;
    tick(2);
    ASYNC_IN[1] = 1'b1;
    tick(3);
    ASYNC_IN[1] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check("glitch_sync", 32'(SYNC_OUT[1]), 32'h0);
    end
    check("glitch_sticky", 32'(STICKY), 32'h0);

    // filter: 4-wide pulse accepted at edge 6
    ASYNC_IN[1] = 1'b1;
    tick(4);
    ASYNC_IN[1] = 1'b0;
    tick(1);
    check("pulse_e5_sync", 32'(SYNC_OUT[1]), 32'h0);
    tick(1);
    check("pulse_e6_sync", 32'(SYNC_OUT[1]), 32'h1);
    tick(1);
    check("pulse_e7_evt", 32'(EVENT[1]), 32'h1);
    tick(12);
    check("pulse_back_low", 32'(SYNC_OUT[1]), 32'h0);
    check("pulse_sticky", 32'(STICKY), 32'h2);
    CLR = 4'b0010;
    tick(1);
    CLR = '0;

    // toggle ch0 and fall ch2 with the same stimulus
    FILT_CNT = '0;
    ASYNC_IN[0] = 1'b0;
    ASYNC_IN[2] = 1'b0;
    tick(8);
    CLR = 4'b0101;
    tick(1);
    CLR = '0;
    tick(1);
    check("pre_tog_sticky", 32'(STICKY), 32'h0);
    n_ev0 = 0; n_hi0 = 0; n_ev2 = 0; n_hi2 = 0;
    prev_ev = EVENT;
    for (int k = 0; k < 60; k++) begin
      if (k % 10 == 0 && k < 50) begin
        ASYNC_IN[0] = ~ASYNC_IN[0];
        ASYNC_IN[2] = ~ASYNC_IN[2];
      end
      tick(1);
      if (EVENT[0] && !prev_ev[0]) n_ev0++;
      if (EVENT[2] && !prev_ev[2]) n_ev2++;
      if (EVENT[0]) n_hi0++;
      if (EVENT[2]) n_hi2++;
      prev_ev = EVENT;
    end
    check("tog_pulses", 32'(n_ev0), 32'd5);
    check("tog_width", 32'(n_hi0), 32'd5);
    check("fall_pulses", 32'(n_ev2), 32'd2);
    check("fall_width", 32'(n_hi2), 32'd2);

    // set wins over clear on ch2
    CLR = 4'b0011;
    tick(1);
    CLR = '0;
    check("only_s2", 32'(STICKY), 32'h4);
    ASYNC_IN[2] = 1'b0;
    tick(4);
    check("sw_evt2", 32'(EVENT[2]), 32'h1);
    CLR = 4'b0100;
    tick(1);
    check("sw_sticky_kept", 32'(STICKY[2]), 32'h1);
    check("sw_irq_kept", 32'(IRQ), 32'h1);
    tick(1);
    CLR = '0;
    check("sw_cleared", 32'(STICKY), 32'h0);
    check("sw_irq_drop", 32'(IRQ), 32'h0);

    // level mode ch3
    ASYNC_IN[3] = 1'b1;
    tick(4);
    check("lvl_sync", 32'(SYNC_OUT[3]), 32'h1);
    check("lvl_evt_hi", 32'(EVENT[3]), 32'h1);
    tick(2);
    ASYNC_IN[3] = 1'b0;
    tick(4);
    check("lvl_evt_lo", 32'(EVENT[3]), 32'h0);
    check("lvl_sticky", 32'(STICKY), 32'h0);

    // reset mid-filter with a sticky flag pending
    ASYNC_IN[0] = 1'b0;
    tick(6);
    check("pre_rst_sticky", 32'(STICKY), 32'h1);
    FILT_CNT = 4'd3;
    tick(1);
    ASYNC_IN[1] = 1'b1;
    tick(4);
    check("midfilt_sync", 32'(SYNC_OUT[1]), 32'h0);
    SYSRST   = 1'b1;
    ASYNC_IN = 4'b0101;
    #1;
    check("arst_sync", 32'(SYNC_OUT), 32'h5);
    check("arst_event", 32'(EVENT), 32'h0);
    check("arst_sticky", 32'(STICKY), 32'h0);
    check("arst_irq", 32'(IRQ), 32'h0);
    tick(2);
    SYSRST = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      check("rel_event", 32'(EVENT), 32'h0);
    end
    check("rel_sync", 32'(SYNC_OUT), 32'h5);
    check("rel_sticky", 32'(STICKY), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
